// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// returns {remainder, quotient} and holds it while the request stays high.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     op1_i,
  input  logic [WIDTH-1:0]     op2_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 done_o
);

  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
  localparam int unsigned WORK_W = 2 * WIDTH + 1;

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORK_W-1:0]    work_q, work_d;
  logic [WIDTH-1:0]     div_q, div_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic [2*WIDTH-1:0]   result_d;
  logic                 done_d;

  logic [WIDTH-1:0]     op1_abs, op2_abs;
  logic [WORK_W-1:0]    shifted, iter;
  logic [WIDTH+1:0]     diff;
  logic [WIDTH-1:0]     quo_mag, rem_mag, quo_fix, rem_fix;

  // Magnitudes are only taken for signed requests with the sign bit set.
  assign op1_abs = (signed_i && op1_i[WIDTH-1]) ? (~op1_i + WIDTH'(1)) : op1_i;
  assign op2_abs = (signed_i && op2_i[WIDTH-1]) ? (~op2_i + WIDTH'(1)) : op2_i;

  // One restoring step; diff's top bit is the borrow of the (WIDTH+1)-bit subtract.
  assign shifted = work_q << 1;
  assign diff    = {1'b0, shifted[WORK_W-1:WIDTH]} - {2'b00, div_q};
  assign iter    = diff[WIDTH+1] ? shifted
                                 : {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};

  assign quo_mag = iter[WIDTH-1:0];
  assign rem_mag = iter[2*WIDTH-1:WIDTH];
  assign quo_fix = qneg_q ? (~quo_mag + WIDTH'(1)) : quo_mag;
  assign rem_fix = rneg_q ? (~rem_mag + WIDTH'(1)) : rem_mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      work_q   <= '0;
      div_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_o <= '0;
      done_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      div_q    <= div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_o <= result_d;
      done_o   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    div_d    = div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_o;
    done_d   = done_o;

    case (state_q)
      FREE: begin
        if (start_i && !annul_i) begin
          if (op2_i == '0) begin
            state_d = BYZERO;
          end else begin
            state_d = ON;
            work_d  = WORK_W'(op1_abs);
            div_d   = op2_abs;
            qneg_d  = signed_i & (op1_i[WIDTH-1] ^ op2_i[WIDTH-1]);
            rneg_d  = signed_i & op1_i[WIDTH-1];
            cnt_d   = '0;
          end
        end
      end
      BYZERO: begin
        result_d = '0;
        done_d   = 1'b1;
        state_d  = END;
      end
      ON: begin
        if (annul_i || !start_i) begin
          state_d = FREE;
        end else begin
          work_d = iter;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = END;
            done_d   = 1'b1;
            result_d = {rem_fix, quo_fix};
          end
        end
      end
      END: begin
        if (annul_i || !start_i) begin
          state_d  = FREE;
          done_d   = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = FREE;
    endcase
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: expected results queued at request time,
// popped and compared when done_o rises.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, annul_i, signed_i;
  logic [31:0] op1_i, op2_i;
  logic [63:0] result_o;
  logic        done_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .annul_i  (annul_i),
    .signed_i (signed_i),
    .op1_i    (op1_i),
    .op2_i    (op2_i),
    .result_o (result_o),
    .done_o   (done_o)
  );

  // Reference divide built on the simulator's own integer arithmetic.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {32'(r), 32'(q)};
  endfunction

  task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    op1_i    = a;
    op2_i    = b;
    signed_i = s;
    annul_i  = 1'b0;
    start_i  = 1'b1;
  endtask

  // Counts rising edges until done_o is seen; -1 when the budget expires.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done_o) break;
    end
    if (!done_o) lat = -1;
  endtask

  task automatic drop_start;
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
    op1_i = '0; op2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_o); end
    n_checks++;
    if (result_o !== 64'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    int lat;
    logic [63:0] exp;
    exp_q.push_back(64'h00000002_0000000E);
    drive_req(32'd100, 32'd7, 1'b0);
    wait_done(lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (lat != 33) begin n_fail++; $display("FAIL udiv_latency got=%0d exp=33", lat); end
    n_checks++;
    if (result_o !== exp) begin n_fail++; $display("FAIL udiv_result got=%h exp=%h", result_o, exp); end
    repeat (3) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (done_o !== 1'b1 || result_o !== exp) begin
        n_fail++; $display("FAIL udiv_hold done=%b result=%h exp=1/%h", done_o, result_o, exp);
      end
    end
    drop_start;
    n_checks++;
    if (done_o !== 1'b0 || result_o !== 64'd0) begin
      n_fail++; $display("FAIL udiv_release done=%b result=%h exp=0/0", done_o, result_o);
    end
  endtask

  // Operands are changed mid-divide; only the values sampled at start count.
  task automatic test_signed;
    int lat;
    logic [63:0] exp;
    exp_q.push_back(64'hFFFFFFFE_FFFFFFF2);
    drive_req(32'hFFFF_FF9C, 32'd7, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    op1_i = 32'h1234_5678; op2_i = 32'd3; signed_i = 1'b0;
    wait_done(lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (lat != 28) begin n_fail++; $display("FAIL sdiv_latency got=%0d exp=28", lat); end
    n_checks++;
    if (result_o !== exp) begin n_fail++; $display("FAIL sdiv_result got=%h exp=%h", result_o, exp); end
    drop_start;
  endtask

  task automatic test_overflow;
    logic [31:0] a_t[2] = '{32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] b_t[2] = '{32'hFFFF_FFFF, 32'h0000_0001};
    logic        s_t[2] = '{1'b1, 1'b0};
    logic [63:0] e_t[2] = '{64'h00000000_80000000, 64'h00000000_FFFFFFFF};
    for (int i = 0; i < 2; i++) begin
      int lat;
      logic [63:0] exp;
      exp_q.push_back(e_t[i]);
      drive_req(a_t[i], b_t[i], s_t[i]);
      wait_done(lat);
      exp = exp_q.pop_front();
      n_checks++;
      if (lat != 33 || result_o !== exp) begin
        n_fail++; $display("FAIL overflow_%0d lat=%0d result=%h exp=33/%h", i, lat, result_o, exp);
      end
      drop_start;
    end
  endtask

  task automatic test_div_zero;
    int lat;
    logic [63:0] exp;
    exp_q.push_back(64'd0);
    drive_req(32'd1234, 32'd0, 1'b1);
    wait_done(lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL divzero_latency got=%0d exp=2", lat); end
    n_checks++;
    if (result_o !== exp) begin n_fail++; $display("FAIL divzero_result got=%h exp=%h", result_o, exp); end
    drop_start;
    n_checks++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL divzero_release done=%b exp=0", done_o); end
  endtask

  task automatic test_annul;
    int lat;
    int seen;
    logic [63:0] exp;
    drive_req(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_o) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL annul_done_cycles got=%0d exp=0", seen); end
    exp_q.push_back(64'h00000002_0000000E);
    drive_req(32'd100, 32'd7, 1'b0);
    wait_done(lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (lat != 33 || result_o !== exp) begin
      n_fail++; $display("FAIL annul_followup lat=%0d result=%h exp=33/%h", lat, result_o, exp);
    end
    drop_start;
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [63:0] exp;
    // Reset in the middle of an iteration.
    drive_req(32'd100, 32'd7, 1'b0);
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (done_o !== 1'b0 || result_o !== 64'd0) begin
      n_fail++; $display("FAIL rst_mid_on done=%b result=%h exp=0/0", done_o, result_o);
    end
    @(negedge clk); start_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    // Reset while a result is being presented clears it without a clock edge.
    exp_q.push_back(64'h00000002_0000000E);
    drive_req(32'd100, 32'd7, 1'b0);
    wait_done(lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (lat != 33 || result_o !== exp) begin
      n_fail++; $display("FAIL rst_recover lat=%0d result=%h exp=33/%h", lat, result_o, exp);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (done_o !== 1'b0 || result_o !== 64'd0) begin
      n_fail++; $display("FAIL rst_in_end done=%b result=%h exp=0/0", done_o, result_o);
    end
    @(negedge clk); start_i = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  // Requests separated by the minimum single FREE cycle, mixed random operands.
  task automatic test_back_to_back;
    for (int i = 0; i < 10; i++) begin
      int lat, exp_lat;
      logic [31:0] a, b;
      logic s;
      logic [63:0] exp;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      s = 1'($urandom_range(0, 1));
      exp_lat = (b == 32'd0) ? 2 : 33;
      exp_q.push_back(model(a, b, s));
      drive_req(a, b, s);
      wait_done(lat);
      exp = exp_q.pop_front();
      n_checks++;
      if (lat != exp_lat || result_o !== exp) begin
        n_fail++;
        $display("FAIL b2b_%0d a=%h b=%h s=%b lat=%0d result=%h exp=%0d/%h",
                 i, a, b, s, lat, result_o, exp_lat, exp);
      end
      drop_start;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
